// File: rtl/w0rm_gpio_port.sv
// ----------------------------------------------------------------------------
// w0rm_gpio_port
//   Memory-mapped GPIO port with per-pin direction, set/clear access to the
//   output register, a synchronised input register and edge-triggered
//   interrupt status with write-1-to-clear.
//
//   Register map (bus_addr):
//     0 DIR      rw   1 = pin driven (gpio_oe)
//     1 OUT      rw   pin drive values (gpio_out)
//     2 IN       ro   synchronised pin values; writes are acked and dropped
//     3 SET      wo   write-1 sets OUT bits, reads return 0
//     4 CLR      wo   write-1 clears OUT bits, reads return 0
//     5 IRQ_EN   rw   per-bit interrupt enable
//     6 IRQ_STAT r/w1c edge events, latched regardless of IRQ_EN
//     7 EDGE_SEL rw   1 = rising edge, 0 = falling edge, per bit
//
//   Ports:
//     clk, reset                 single clock, synchronous active-high reset
//     bus_valid/write/addr/wdata CPU request
//     bus_ready, bus_ack         handshake outputs
//     bus_rdata                  read data, valid only while bus_ack=1
//     gpio_in                    asynchronous pin inputs
//     gpio_out, gpio_oe          pin drive values and output enables
//     irq                        level interrupt, OR of IRQ_STAT & IRQ_EN
//     dbg_state                  bus FSM state (0 = IDLE, 1 = RESP)
//
//   Handshake: a request is accepted on a rising edge where bus_valid=1 and
//   bus_ready=1. bus_ready is high only in IDLE, so after acceptance the FSM
//   sits in RESP for exactly one cycle with bus_ack=1 and bus_ready=0, then
//   returns to IDLE. bus_valid seen in RESP is ignored. Writes take effect at
//   the acceptance edge; read data is captured at that same edge.
// ----------------------------------------------------------------------------
module w0rm_gpio_port #(
   parameter int PORT_WIDTH = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  bus_valid,
   input  logic                  bus_write,
   input  logic [2:0]            bus_addr,
   input  logic [DATA_WIDTH-1:0] bus_wdata,
   output logic                  bus_ready,
   output logic                  bus_ack,
   output logic [DATA_WIDTH-1:0] bus_rdata,
   input  logic [PORT_WIDTH-1:0] gpio_in,
   output logic [PORT_WIDTH-1:0] gpio_out,
   output logic [PORT_WIDTH-1:0] gpio_oe,
   output logic                  irq,
   output logic                  dbg_state
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RESP = 1'b1;

   localparam logic [2:0] A_DIR   = 3'd0;
   localparam logic [2:0] A_OUT   = 3'd1;
   localparam logic [2:0] A_IN    = 3'd2;
   localparam logic [2:0] A_SET   = 3'd3;
   localparam logic [2:0] A_CLR   = 3'd4;
   localparam logic [2:0] A_IEN   = 3'd5;
   localparam logic [2:0] A_ISTAT = 3'd6;
   localparam logic [2:0] A_ESEL  = 3'd7;

   logic [0:0]            r_state;
   logic [PORT_WIDTH-1:0] r_dir;
   logic [PORT_WIDTH-1:0] r_out;
   logic [PORT_WIDTH-1:0] r_ien;
   logic [PORT_WIDTH-1:0] r_istat;
   logic [PORT_WIDTH-1:0] r_esel;
   logic [PORT_WIDTH-1:0] r_s1;
   logic [PORT_WIDTH-1:0] r_s2;
   logic [PORT_WIDTH-1:0] r_s3;
   logic [1:0]            r_inhibit;
   logic [PORT_WIDTH-1:0] r_rdata;

   logic                  w_accept;
   logic                  w_wr;
   logic [PORT_WIDTH-1:0] w_wdata;
   logic [PORT_WIDTH-1:0] w_rd_sel;
   logic [PORT_WIDTH-1:0] w_edge;
   logic [PORT_WIDTH-1:0] w_w1c;
   logic                  w_edge_en;
   logic                  w_unused_wdata;

   // Upper write-data bits carry no meaning for this port.
   assign w_unused_wdata = &{1'b0, bus_wdata};

   assign bus_ready = (r_state == ST_IDLE) && !reset;
   assign bus_ack   = (r_state == ST_RESP) && !reset;
   assign dbg_state = r_state[0];
   assign w_accept  = bus_valid && bus_ready;
   assign w_wr      = w_accept && bus_write;
   assign w_wdata   = bus_wdata[PORT_WIDTH-1:0];
   assign gpio_out  = r_out;
   assign gpio_oe   = r_dir;
   assign irq       = !reset && (|(r_istat & r_ien));

   // Inhibit counter holds off edge detection while the synchroniser refills
   // after reset, so pins already high at release do not look like edges.
   assign w_edge_en = (r_inhibit == 2'd0);
   assign w_edge    = w_edge_en ? ((r_esel & r_s2 & ~r_s3) | (~r_esel & ~r_s2 & r_s3))
                                : '0;
   assign w_w1c     = (w_wr && (bus_addr == A_ISTAT)) ? w_wdata : '0;

   always_comb begin
      w_rd_sel = '0;
      case (bus_addr)
         A_DIR:   w_rd_sel = r_dir;
         A_OUT:   w_rd_sel = r_out;
         A_IN:    w_rd_sel = r_s2;
         A_IEN:   w_rd_sel = r_ien;
         A_ISTAT: w_rd_sel = r_istat;
         A_ESEL:  w_rd_sel = r_esel;
         default: w_rd_sel = '0;
      endcase
   end

   always_comb begin
      bus_rdata = '0;
      if (bus_ack) bus_rdata[PORT_WIDTH-1:0] = r_rdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_dir     <= '0;
         r_out     <= '0;
         r_ien     <= '0;
         r_istat   <= '0;
         r_esel    <= '0;
         r_s1      <= '0;
         r_s2      <= '0;
         r_s3      <= '0;
         r_inhibit <= 2'd3;
         r_rdata   <= '0;
      end else begin
         r_s1 <= gpio_in;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
         if (r_inhibit != 2'd0) r_inhibit <= r_inhibit - 2'd1;

         // New events are OR-ed in after the clear so a coincident event wins.
         r_istat <= (r_istat & ~w_w1c) | w_edge;

         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_state <= ST_RESP;
                  r_rdata <= bus_write ? '0 : w_rd_sel;
                  if (bus_write) begin
                     case (bus_addr)
                        A_DIR:   r_dir  <= w_wdata;
                        A_OUT:   r_out  <= w_wdata;
                        A_SET:   r_out  <= r_out | w_wdata;
                        A_CLR:   r_out  <= r_out & ~w_wdata;
                        A_IEN:   r_ien  <= w_wdata;
                        A_ESEL:  r_esel <= w_wdata;
                        default: ;
                     endcase
                  end
               end
            end
            ST_RESP: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_w0rm_gpio_port.sv
// ----------------------------------------------------------------------------
// tb_w0rm_gpio_port
//   Directed bench for w0rm_gpio_port. Drivers push the expected response of
//   every request into a queue; a monitor pops on each bus_ack and compares
//   read data. Pin-level outputs are checked directly on the falling edge.
// ----------------------------------------------------------------------------
module tb_w0rm_gpio_port;

   localparam int PW = 8;
   localparam int DW = 32;

   // ---------------- clock / reset ----------------
   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          bus_valid = 1'b0;
   logic          bus_write = 1'b0;
   logic [2:0]    bus_addr = '0;
   logic [DW-1:0] bus_wdata = '0;
   logic          bus_ready;
   logic          bus_ack;
   logic [DW-1:0] bus_rdata;
   logic [PW-1:0] gpio_in = '0;
   logic [PW-1:0] gpio_out;
   logic [PW-1:0] gpio_oe;
   logic          irq;
   logic          dbg_state;

   always #5 clk = ~clk;

   w0rm_gpio_port #(.PORT_WIDTH(PW), .DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus_valid (bus_valid),
      .bus_write (bus_write),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_ready (bus_ready),
      .bus_ack   (bus_ack),
      .bus_rdata (bus_rdata),
      .gpio_in   (gpio_in),
      .gpio_out  (gpio_out),
      .gpio_oe   (gpio_oe),
      .irq       (irq),
      .dbg_state (dbg_state)
   );

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] exp_q[$];
   logic          is_rd_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks (called on a falling edge) ----------------
   task automatic bus_xfer(input logic wr, input logic [2:0] addr,
                           input logic [31:0] data, input logic [31:0] exp);
      int waited = 0;
      while (!bus_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check("ready_wait", 32'(bus_ready), 32'd1);
      if (!bus_ready) return;
      is_rd_q.push_back(!wr);
      exp_q.push_back(exp);
      bus_valid = 1'b1;
      bus_write = wr;
      bus_addr  = addr;
      bus_wdata = data;
      @(posedge clk);
      #1;
      bus_valid = 1'b0;
      bus_write = 1'b0;
      bus_wdata = '0;
      @(negedge clk);
      check("ack_latency", 32'(bus_ack), 32'd1);
      check("ready_low_in_ack", 32'(bus_ready), 32'd0);
      check("dbg_state_resp", 32'(dbg_state), 32'd1);
   endtask

   task automatic bus_wr(input logic [2:0] addr, input logic [31:0] data);
      bus_xfer(1'b1, addr, data, 32'd0);
   endtask

   task automatic bus_rd(input logic [2:0] addr, input logic [31:0] exp);
      bus_xfer(1'b0, addr, 32'd0, exp);
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (bus_ack) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ack actual=1 expected=0 addr=%0d", bus_addr);
         end else begin
            logic [DW-1:0] e;
            logic          r;
            e = exp_q.pop_front();
            r = is_rd_q.pop_front();
            if (r) check("rdata", bus_rdata, e);
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(bus_ready), 32'd0);
      check("rst_ack", 32'(bus_ack), 32'd0);
      check("rst_rdata", bus_rdata, 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_out", 32'(gpio_out), 32'd0);
      check("rst_oe", 32'(gpio_oe), 32'd0);
      check("rst_state", 32'(dbg_state), 32'd0);
      reset = 1'b0;
      #1;
      check("ready_after_rst", 32'(bus_ready), 32'd1);

      // DIR / OUT writes visible with the ack
      bus_wr(3'd0, 32'h0F);
      check("gpio_oe", 32'(gpio_oe), 32'h0F);
      bus_wr(3'd1, 32'hA5);
      check("gpio_out", 32'(gpio_out), 32'hA5);
      bus_rd(3'd0, 32'h0F);
      bus_rd(3'd1, 32'hA5);

      // SET / CLR
      bus_wr(3'd3, 32'h0A);
      bus_rd(3'd1, 32'hAF);
      bus_wr(3'd4, 32'h81);
      check("gpio_out_clr", 32'(gpio_out), 32'h2E);
      bus_rd(3'd1, 32'h2E);
      bus_rd(3'd3, 32'h00);
      bus_rd(3'd4, 32'h00);

      // IN is read-only
      bus_wr(3'd2, 32'h55);
      bus_rd(3'd2, 32'h00);

      // Rising edge on bit 7 with 2-cycle sync latency
      bus_wr(3'd7, 32'h80);
      bus_wr(3'd5, 32'h80);
      @(negedge clk);
      gpio_in = 8'h80;            // before edge k
      @(negedge clk);             // after k
      check("irq_after_k", 32'(irq), 32'd0);
      @(negedge clk);             // after k+1
      check("irq_after_k1", 32'(irq), 32'd0);
      bus_rd(3'd2, 32'h80);       // accepted at k+2, returns IN as of k+1
      check("irq_after_k2", 32'(irq), 32'd1);
      bus_rd(3'd6, 32'h80);
      bus_wr(3'd6, 32'h80);
      check("irq_w1c", 32'(irq), 32'd0);
      bus_wr(3'd7, 32'h00);       // selecting falling on a steady-high pin
      bus_rd(3'd6, 32'h00);

      // W1C coincident with a new event on bit 0
      bus_wr(3'd7, 32'h01);
      @(negedge clk);
      gpio_in = 8'h81;
      repeat (4) @(negedge clk);
      bus_rd(3'd6, 32'h01);
      gpio_in = 8'h80;
      repeat (4) @(negedge clk);
      gpio_in = 8'h81;            // before edge k
      @(negedge clk);
      @(negedge clk);
      bus_wr(3'd6, 32'h01);       // accepted at k+2 together with the event
      bus_rd(3'd6, 32'h01);
      bus_wr(3'd6, 32'h01);
      bus_rd(3'd6, 32'h00);

      // Pins high through reset release raise no event
      @(negedge clk);
      gpio_in = 8'hFF;
      reset   = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      bus_wr(3'd5, 32'hFF);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("irq_inhibit", 32'(irq), 32'd0);
      end
      bus_rd(3'd6, 32'h00);
      bus_wr(3'd7, 32'h00);
      gpio_in = 8'h00;
      repeat (3) @(negedge clk);
      bus_rd(3'd6, 32'hFF);
      check("irq_fall_all", 32'(irq), 32'd1);

      // Reset during RESP of a read
      bus_wr(3'd0, 32'h3C);
      bus_wr(3'd1, 32'h5A);
      @(negedge clk);
      bus_valid = 1'b1;
      bus_write = 1'b0;
      bus_addr  = 3'd0;
      @(posedge clk);
      #1;
      bus_valid = 1'b0;
      reset     = 1'b1;
      @(negedge clk);
      check("rst_resp_ack", 32'(bus_ack), 32'd0);
      check("rst_resp_rdata", bus_rdata, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_resp_ready", 32'(bus_ready), 32'd1);
      check("rst_resp_oe", 32'(gpio_oe), 32'd0);
      check("rst_resp_out", 32'(gpio_out), 32'd0);
      check("rst_resp_irq", 32'(irq), 32'd0);
      bus_rd(3'd0, 32'h00);
      bus_rd(3'd5, 32'h00);
      bus_rd(3'd7, 32'h00);

      repeat (4) @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
